// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and default constants for the slow-clock divider
//
// Purpose : FSM state encoding used by clk_div_ctrl, plus the default divider width and reset ratio.
// Ports   : none (package)

package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } div_state_e;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;
    localparam int unsigned DIV_N_DEFAULT     = 6;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter and slow_clk toggle flop with runtime ratio
//
// Purpose : Counts 0..n_i-1 while en_i is high and toggles slow_clk at the wrap. It holds when en_i is low.
//           It produces registered edge ticks and a combinational falling-boundary strobe.
// Ports   :
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset (forces slow_clk low)
//   en_i         count enable; counter and slow_clk hold when low
//   n_i          half-period in clk cycles (>= 1)
//   slow_clk_o   divided clock, straight from a flop
//   cnt_zero_o   counter currently at 0
//   fall_o       this cycle ends a high phase (1->0 toggle at the next edge)
//   tick_rise_o  first cycle with slow_clk high after a rise
//   tick_fall_o  first cycle with slow_clk low after a fall

module clk_div_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             slow_clk_o,
    output logic             cnt_zero_o,
    output logic             fall_o,
    output logic             tick_rise_o,
    output logic             tick_fall_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             slow_q, slow_d;
    logic             tick_rise_q, tick_fall_q;
    logic             wrap;

    // n_i is never zero, so n_i-1 cannot underflow.
    assign wrap = en_i && (cnt_q == (n_i - WIDTH'(1)));

    always_comb begin
        cnt_d  = cnt_q;
        slow_d = slow_q;
        if (en_i) begin
            if (wrap) begin
                cnt_d  = '0;
                slow_d = ~slow_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            slow_q      <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slow_q      <= slow_d;
            tick_rise_q <= wrap && !slow_q;
            tick_fall_q <= wrap && slow_q;
        end
    end

    assign slow_clk_o  = slow_q;
    assign cnt_zero_o  = (cnt_q == '0);
    assign fall_o      = wrap && slow_q;
    assign tick_rise_o = tick_rise_q;
    assign tick_fall_o = tick_fall_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time controller for the programmable slow-clock divider
//
// Purpose : Starts and stops the divider on div_en and accepts new half-period ratios over a valid/ready port.
//           Ratio changes and stops take effect only at a slow_clk falling boundary, so phases are never cut short.
// Ports   :
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   div_en     1 = run, 0 = stop at the next falling boundary
//   cfg_valid  config request valid
//   cfg_n      requested half-period (1..2^WIDTH-1; 0 is rejected)
//   cfg_ready  request can be accepted this cycle
//   cfg_err    one-cycle pulse after a request with cfg_n == 0
//   cur_n      half-period currently in force
//   slow_clk   divided clock
//   tick_rise  first cycle of each high phase
//   tick_fall  first cycle of each low phase
//   busy       divider in RUN or PEND

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = DIV_WIDTH_DEFAULT,
    parameter int unsigned N_DEFAULT = DIV_N_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_n,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cur_n,
    output logic             slow_clk,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             busy
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] cur_n_q, cur_n_d;
    logic [WIDTH-1:0] pend_n_q, pend_n_d;
    logic             pend_v_q, pend_v_d;
    logic             cfg_err_q, cfg_err_d;

    logic             core_en;
    logic             core_slow;
    logic             core_cnt_zero;
    logic             core_fall;
    logic             accept;
    logic             accept_ok;
    logic             stop_now;

    assign cfg_ready = (state_q != ST_PEND);
    assign accept    = cfg_valid && cfg_ready;
    assign accept_ok = accept && (cfg_n != '0);

    // If STOP begins exactly at the start of a low phase, nothing remains to finish. Freeze the counter and drop to OFF.
    assign stop_now  = (state_q == ST_STOP) && !div_en && !core_slow && core_cnt_zero;
    assign core_en   = (state_q != ST_OFF) && !stop_now;

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .en_i        (core_en),
        .n_i         (cur_n_q),
        .slow_clk_o  (core_slow),
        .cnt_zero_o  (core_cnt_zero),
        .fall_o      (core_fall),
        .tick_rise_o (tick_rise),
        .tick_fall_o (tick_fall)
    );

    always_comb begin
        state_d   = state_q;
        cur_n_d   = cur_n_q;
        pend_n_d  = pend_n_q;
        pend_v_d  = pend_v_q;
        cfg_err_d = accept && (cfg_n == '0);

        unique case (state_q)
            ST_OFF: begin
                // Divider is idle, so a new ratio can take effect immediately.
                if (accept_ok) begin
                    cur_n_d = cfg_n;
                end
                if (div_en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Go to PEND even if div_en drops in the same cycle. PEND then applies the ratio and stops at the boundary.
                if (accept_ok) begin
                    pend_n_d = cfg_n;
                    state_d  = ST_PEND;
                end else if (!div_en) begin
                    state_d = ST_STOP;
                end
            end

            ST_PEND: begin
                // The falling-edge cycle still counts with the old ratio. The new ratio starts with the low phase.
                if (core_fall) begin
                    cur_n_d = pend_n_q;
                    state_d = div_en ? ST_RUN : ST_OFF;
                end
            end

            ST_STOP: begin
                // While the current phase finishes, a ratio accepted here is held in pend_n/pend_v.
                if (accept_ok) begin
                    pend_n_d = cfg_n;
                    pend_v_d = 1'b1;
                end
                if (div_en) begin
                    state_d  = (pend_v_q || accept_ok) ? ST_PEND : ST_RUN;
                    pend_v_d = 1'b0;
                end else if (core_fall || stop_now) begin
                    state_d  = ST_OFF;
                    pend_v_d = 1'b0;
                    if (accept_ok) begin
                        cur_n_d = cfg_n;
                    end else if (pend_v_q) begin
                        cur_n_d = pend_n_q;
                    end
                end
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OFF;
            cur_n_q   <= WIDTH'(N_DEFAULT);
            pend_n_q  <= '0;
            pend_v_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_n_q   <= cur_n_d;
            pend_n_q  <= pend_n_d;
            pend_v_q  <= pend_v_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cur_n    = cur_n_q;
    assign cfg_err  = cfg_err_q;
    assign slow_clk = core_slow;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_PEND);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl (directed table, corner sequences, random vs model)

module tb_clk_div_ctrl;

    localparam int W  = 8;
    localparam int ND = 6;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         div_en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_n = '0;
    logic         cfg_ready, cfg_err, slow_clk, tick_rise, tick_fall, busy;
    logic [W-1:0] cur_n;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_ctrl #(.WIDTH(W), .N_DEFAULT(ND)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .div_en    (div_en),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_n     (cur_n),
        .slow_clk  (slow_clk),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the divider is described as "on/stopping", a ratio, an optional pending ratio,
    // the current level and the number of cycles left in the current phase.
    bit m_on, m_stop, m_pend_v, m_lvl, m_trise, m_tfall, m_err;
    int m_n, m_pend, m_left;

    task model_reset();
        m_on = 0; m_stop = 0; m_pend_v = 0; m_lvl = 0;
        m_trise = 0; m_tfall = 0; m_err = 0;
        m_n = ND; m_pend = 0; m_left = 0;
    endtask

    task model_advance();
        if (m_left == 1) begin
            if (m_lvl) m_tfall = 1; else m_trise = 1;
            m_lvl  = !m_lvl;
            m_left = m_n;
        end else begin
            m_left = m_left - 1;
        end
    endtask

    task model_step();
        bit ready, acc, acc_ok, adv, fall;
        ready   = !(m_on && !m_stop && m_pend_v);
        acc     = cfg_valid && ready;
        acc_ok  = acc && (cfg_n != 0);
        m_err   = acc && (cfg_n == 0);
        m_trise = 0;
        m_tfall = 0;
        adv     = 0;
        fall    = m_on && (m_left == 1) && m_lvl;
        if (!m_on) begin
            if (acc_ok) m_n = int'(cfg_n);
            if (div_en) begin
                m_on = 1; m_stop = 0; m_lvl = 0; m_left = m_n;
            end
        end else if (!m_stop) begin
            adv = 1;
            if (m_pend_v) begin
                if (fall) begin
                    m_n = m_pend; m_pend_v = 0;
                    if (!div_en) m_on = 0;
                end
            end else if (acc_ok) begin
                m_pend = int'(cfg_n); m_pend_v = 1;
            end else if (!div_en) begin
                m_stop = 1;
            end
        end else begin
            if (acc_ok) begin
                m_pend = int'(cfg_n); m_pend_v = 1;
            end
            if (div_en) begin
                m_stop = 0; adv = 1;
            end else if (fall || (!m_lvl && m_left == m_n)) begin
                if (m_pend_v) m_n = m_pend;
                m_pend_v = 0; m_on = 0; m_stop = 0;
                adv = fall;
            end else begin
                adv = 1;
            end
        end
        if (adv) model_advance();
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_model(input string nm);
        logic [13:0] got, exp;
        got = {slow_clk, busy, cfg_ready, cfg_err, tick_rise, tick_fall, cur_n};
        exp = {m_lvl, (m_on && !m_stop), !(m_on && !m_stop && m_pend_v), m_err,
               m_trise, m_tfall, 8'(m_n)};
        check(nm, 32'(got), 32'(exp));
    endtask

    // Drive inputs (at a falling edge), let one rising edge pass, compare on the next falling edge.
    task automatic run_cycle(input bit de, input bit cv, input logic [W-1:0] cn);
        div_en = de; cfg_valid = cv; cfg_n = cn;
        @(posedge clk);
        @(negedge clk);
        check_model("model");
    endtask

    typedef struct {
        bit         de;
        bit         cv;
        logic [7:0] cn;
        int         ncyc;
        bit         e_slow;
        logic [7:0] e_curn;
        bit         e_ready;
        bit         e_busy;
        bit         e_err;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Cycle counts are measured from the first div_en=1 cycle after reset (RUN = cycle 1).
        tbl[0]  = '{1, 0, 8'd0, 6, 0, 8'd6, 1, 1, 0};  // c6: still low
        tbl[1]  = '{1, 0, 8'd0, 1, 1, 8'd6, 1, 1, 0};  // c7: first rise at RUN+6
        tbl[2]  = '{1, 0, 8'd0, 5, 1, 8'd6, 1, 1, 0};  // c12: last high cycle
        tbl[3]  = '{1, 0, 8'd0, 1, 0, 8'd6, 1, 1, 0};  // c13: fall
        tbl[4]  = '{1, 0, 8'd0, 6, 1, 8'd6, 1, 1, 0};  // c19: second rise, period 12
        tbl[5]  = '{1, 1, 8'd3, 1, 1, 8'd6, 0, 1, 0};  // c20: PEND, not ready
        tbl[6]  = '{1, 0, 8'd0, 4, 1, 8'd6, 0, 1, 0};  // c24: old high phase completes
        tbl[7]  = '{1, 0, 8'd0, 1, 0, 8'd3, 1, 1, 0};  // c25: fall applies N=3
        tbl[8]  = '{1, 0, 8'd0, 3, 1, 8'd3, 1, 1, 0};  // c28: 3-cycle low
        tbl[9]  = '{1, 0, 8'd0, 3, 0, 8'd3, 1, 1, 0};  // c31: 3-cycle high
        tbl[10] = '{1, 1, 8'd0, 1, 0, 8'd3, 1, 1, 1};  // c32: cfg_n=0 rejected
        tbl[11] = '{1, 0, 8'd0, 3, 1, 8'd3, 1, 1, 0};  // c35: mid high
        tbl[12] = '{0, 0, 8'd0, 1, 1, 8'd3, 1, 0, 0};  // c36: STOP, high continues
        tbl[13] = '{0, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0};  // c37: fall, OFF
        tbl[14] = '{0, 0, 8'd0, 5, 0, 8'd3, 1, 0, 0};  // c42: stays off
        tbl[15] = '{1, 0, 8'd0, 3, 0, 8'd3, 1, 1, 0};  // c45: restarted from cnt 0
        tbl[16] = '{1, 0, 8'd0, 1, 1, 8'd3, 1, 1, 0};  // c46: rise N after restart
        tbl[17] = '{1, 1, 8'd1, 1, 1, 8'd3, 0, 1, 0};  // c47: request N=1
        tbl[18] = '{1, 0, 8'd0, 2, 0, 8'd1, 1, 1, 0};  // c49: applied at fall
        tbl[19] = '{1, 0, 8'd0, 1, 1, 8'd1, 1, 1, 0};  // c50: period 2
        tbl[20] = '{1, 0, 8'd0, 1, 0, 8'd1, 1, 1, 0};  // c51

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_slow", 32'(slow_clk), 0);
        check("rst_curn", 32'(cur_n), ND);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_ticks", 32'({tick_rise, tick_fall}), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < tbl[i].ncyc; k++)
                run_cycle(tbl[i].de, (k == 0) ? tbl[i].cv : 1'b0, tbl[i].cn);
            check($sformatf("tbl%0d_slow", i), 32'(slow_clk), 32'(tbl[i].e_slow));
            check($sformatf("tbl%0d_curn", i), 32'(cur_n), 32'(tbl[i].e_curn));
            check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
        end

        // N=1: ticks alternate every cycle
        run_cycle(1, 0, 8'd0);
        check("n1_rise", 32'({tick_rise, tick_fall}), 32'(2'b10));
        run_cycle(1, 0, 8'd0);
        check("n1_fall", 32'({tick_rise, tick_fall}), 32'(2'b01));

        // Reset in the middle of PEND, while slow_clk is high
        run_cycle(1, 1, 8'd9);
        check("pend_slow_hi", 32'(slow_clk), 1);
        check("pend_ready", 32'(cfg_ready), 0);
        div_en = 1'b0; cfg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_slow", 32'(slow_clk), 0);
        check("arst_curn", 32'(cur_n), ND);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) run_cycle(1, 0, 8'd0);
        check("post_rst_rise", 32'(slow_clk), 1);
        check("post_rst_curn", 32'(cur_n), ND);

        // Randomised traffic against the model
        for (int k = 0; k < 4000; k++) begin
            bit         de;
            bit         cv;
            logic [7:0] cn;
            int         r;
            de = div_en;
            if ($urandom_range(0, 24) == 0) de = !div_en;
            cv = ($urandom_range(0, 6) == 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      cn = 8'd0;
            else if (r < 8)  cn = 8'($urandom_range(1, 4));
            else             cn = 8'($urandom_range(5, 20));
            run_cycle(de, cv, cn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
